// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types and constants for the mem_bus_ctrl memory access sequencer.
// Provides the default data width macro DATA_WIDTH when not supplied externally.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package mem_bus_ctrl_pkg;

  localparam int MBC_DATA_WIDTH = `DATA_WIDTH;
  localparam int MBC_MAX_WAIT   = 15;

  typedef enum logic [1:0] {
    MBC_IDLE   = 2'd0,
    MBC_SETUP  = 2'd1,
    MBC_ACCESS = 2'd2,
    MBC_HOLD   = 2'd3
  } mbc_state_e;

  // Counter must hold WAIT_STATES; never narrower than one bit.
  function automatic int mbc_cnt_width(input int wait_states);
    return (wait_states < 1) ? 1 : $clog2(wait_states + 1);
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_wait_counter.sv
// Loadable down-counter with zero flag; times the ACCESS phase of mem_bus_ctrl.
module wait_counter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/mem_bus_ctrl.sv
// Fixed-timing chip-select/strobe sequencer for external RAM/ROM, one access in flight.
// Optional macro MEM_READY_EN adds a mem_ready input that stretches the last ACCESS cycle.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = `DATA_WIDTH,
  parameter int ADDR_WIDTH  = 2 * `DATA_WIDTH,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
`ifdef MEM_READY_EN
  input  logic                  mem_ready,
`endif
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe
);

  localparam int CNT_W = mbc_cnt_width(WAIT_STATES);

  if (WAIT_STATES < 0 || WAIT_STATES > MBC_MAX_WAIT) begin : g_bad_wait
    $error("mem_bus_ctrl: WAIT_STATES out of range 0..15");
  end

  mbc_state_e            state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  mem_cs_q, mem_cs_d;
  logic                  mem_we_q, mem_we_d;
  logic                  mem_oe_q, mem_oe_d;
  logic                  cnt_load, cnt_dec, cnt_zero;
  logic                  access_ready;

`ifdef MEM_READY_EN
  assign access_ready = mem_ready;
`else
  assign access_ready = 1'b1;
`endif

  wait_counter #(
    .WIDTH (CNT_W)
  ) u_wait_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (CNT_W'(WAIT_STATES)),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;

    case (state_q)
      MBC_IDLE: begin
        if (req) begin
          state_d     = MBC_SETUP;
          we_d        = we;
          mem_addr_d  = addr_in;
          mem_wdata_d = wdata;
        end
      end
      MBC_SETUP: begin
        state_d  = MBC_ACCESS;
        cnt_load = 1'b1;
      end
      MBC_ACCESS: begin
        cnt_dec = 1'b1;
        if (cnt_zero && access_ready) begin
          state_d = MBC_HOLD;
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
        end
      end
      MBC_HOLD: state_d = MBC_IDLE;
      default:  state_d = MBC_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    busy_d   = (state_d != MBC_IDLE);
    mem_cs_d = (state_d != MBC_IDLE);
    mem_we_d = (state_d == MBC_ACCESS) && we_d;
    mem_oe_d = (state_d == MBC_ACCESS) && !we_d;
    done_d   = (state_d == MBC_HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= MBC_IDLE;
      we_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_oe_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      mem_oe_q    <= mem_oe_d;
    end
  end

  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_cs    = mem_cs_q;
  assign mem_we    = mem_we_q;
  assign mem_oe    = mem_oe_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: two instances (WAIT_STATES 1 and 0) against a phase-count model.
`timescale 1ns/1ps

module tb_mem_bus_ctrl;

  localparam int DW = 8;
  localparam int AW = 16;
`ifdef MEM_READY_EN
  localparam bit HAS_READY = 1'b1;
`else
  localparam bit HAS_READY = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_v [2];
  logic          req_v   [2];
  logic          we_v    [2];
  logic [AW-1:0] addr_v  [2];
  logic [DW-1:0] wdata_v [2];
  logic          ready_v [2];
  logic [DW-1:0] rdata_v [2];
  logic          busy_v  [2];
  logic          done_v  [2];
  logic [AW-1:0] maddr_v [2];
  logic [DW-1:0] mwdata_v[2];
  logic [DW-1:0] mrdata_v[2];
  logic          cs_v    [2];
  logic          mwe_v   [2];
  logic          oe_v    [2];

  logic [DW-1:0] rom [256];
  assign mrdata_v[0] = rom[maddr_v[0][7:0]];
  assign mrdata_v[1] = rom[maddr_v[1][7:0]];

  mem_bus_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(1)) u_dut0 (
    .clk(clk), .reset(reset_v[0]), .req(req_v[0]), .we(we_v[0]), .addr_in(addr_v[0]),
    .wdata(wdata_v[0]), .rdata(rdata_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .mem_addr(maddr_v[0]), .mem_wdata(mwdata_v[0]), .mem_rdata(mrdata_v[0]),
`ifdef MEM_READY_EN
    .mem_ready(ready_v[0]),
`endif
    .mem_cs(cs_v[0]), .mem_we(mwe_v[0]), .mem_oe(oe_v[0])
  );

  mem_bus_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WAIT_STATES(0)) u_dut1 (
    .clk(clk), .reset(reset_v[1]), .req(req_v[1]), .we(we_v[1]), .addr_in(addr_v[1]),
    .wdata(wdata_v[1]), .rdata(rdata_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .mem_addr(maddr_v[1]), .mem_wdata(mwdata_v[1]), .mem_rdata(mrdata_v[1]),
`ifdef MEM_READY_EN
    .mem_ready(ready_v[1]),
`endif
    .mem_cs(cs_v[1]), .mem_we(mwe_v[1]), .mem_oe(oe_v[1])
  );

  // Model: phase 0 idle, 1 setup, 2..2+ws access, 3+ws hold.
  int            ws_of   [2] = '{1, 0};
  int            m_phase [2];
  logic          m_we    [2];
  logic [AW-1:0] m_addr  [2];
  logic [DW-1:0] m_wdata [2];
  logic [DW-1:0] m_rdata [2];

  int checks = 0;
  int errors = 0;
  int done_cnt[2];
  int oe_cnt  [2];
  int we_cnt  [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input int i);
    int ws;
    ws = ws_of[i];
    if (reset_v[i]) begin
      m_phase[i] = 0; m_we[i] = 1'b0; m_addr[i] = '0; m_wdata[i] = '0; m_rdata[i] = '0;
    end else if (m_phase[i] == 0) begin
      if (req_v[i]) begin
        m_phase[i] = 1; m_we[i] = we_v[i]; m_addr[i] = addr_v[i]; m_wdata[i] = wdata_v[i];
      end
    end else if (m_phase[i] == 2 + ws) begin
      if (!HAS_READY || ready_v[i]) begin
        if (!m_we[i]) m_rdata[i] = rom[m_addr[i][7:0]];
        m_phase[i] = 3 + ws;
      end
    end else if (m_phase[i] == 3 + ws) begin
      m_phase[i] = 0;
    end else begin
      m_phase[i]++;
    end
  endtask

  task automatic check_outputs(input int i);
    int   ws;
    logic acc;
    ws  = ws_of[i];
    acc = (m_phase[i] >= 2) && (m_phase[i] <= 2 + ws);
    check($sformatf("busy[%0d]", i),      busy_v[i],   m_phase[i] != 0);
    check($sformatf("mem_cs[%0d]", i),    cs_v[i],     m_phase[i] != 0);
    check($sformatf("mem_we[%0d]", i),    mwe_v[i],    acc && m_we[i]);
    check($sformatf("mem_oe[%0d]", i),    oe_v[i],     acc && !m_we[i]);
    check($sformatf("done[%0d]", i),      done_v[i],   m_phase[i] == 3 + ws);
    check($sformatf("mem_addr[%0d]", i),  maddr_v[i],  m_addr[i]);
    check($sformatf("mem_wdata[%0d]", i), mwdata_v[i], m_wdata[i]);
    check($sformatf("rdata[%0d]", i),     rdata_v[i],  m_rdata[i]);
  endtask

  task automatic tick();
    for (int i = 0; i < 2; i++) model_edge(i);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_outputs(i);
      if (done_v[i] === 1'b1) done_cnt[i]++;
      if (oe_v[i] === 1'b1)   oe_cnt[i]++;
      if (mwe_v[i] === 1'b1)  we_cnt[i]++;
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      done_cnt[i] = 0; oe_cnt[i] = 0; we_cnt[i] = 0;
    end
  endtask

  task automatic idle_inputs(input int i);
    reset_v[i] = 1'b0; req_v[i] = 1'b0; we_v[i] = 1'b0;
    addr_v[i] = '0; wdata_v[i] = '0; ready_v[i] = 1'b1;
  endtask

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = DW'($urandom);
    rom[8'hA5] = 8'h3C;
    rom[8'h77] = 8'h5A;
    for (int i = 0; i < 2; i++) begin
      idle_inputs(i);
      reset_v[i] = 1'b1;
      m_phase[i] = 0; m_we[i] = 1'b0; m_addr[i] = '0; m_wdata[i] = '0; m_rdata[i] = '0;
    end
    @(negedge clk);
    tick();
    tick();
    reset_v[0] = 1'b0;
    reset_v[1] = 1'b0;
    tick();

    // Read on WAIT_STATES=1 and write on WAIT_STATES=0, side by side.
    clear_counts();
    req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 16'h12A5;
    req_v[1] = 1'b1; we_v[1] = 1'b1; addr_v[1] = 16'hFFFF; wdata_v[1] = 8'hA5;
    tick();
    req_v[0] = 1'b0; req_v[1] = 1'b0;
    repeat (4) tick();
    check("read_oe_cycles", oe_cnt[0], 2);
    check("read_we_cycles", we_cnt[0], 0);
    check("read_done_pulses", done_cnt[0], 1);
    check("read_rdata_3c", rdata_v[0], 8'h3C);
    check("write_we_cycles", we_cnt[1], 1);
    check("write_done_pulses", done_cnt[1], 1);
    check("write_rdata_kept", rdata_v[1], 8'h00);

    // req held high: one access per 5 cycles, nothing extra while busy.
    clear_counts();
    for (int k = 0; k < 20; k++) begin
      req_v[0] = 1'b1; we_v[0] = 1'($urandom); addr_v[0] = AW'($urandom); wdata_v[0] = DW'($urandom);
      tick();
    end
    check("held_req_done_pulses", done_cnt[0], 4);
    idle_inputs(0);
    repeat (3) tick();

    // Reset in the second ACCESS cycle of a read, after a read left rdata non-zero.
    req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 16'h00A5;
    tick();
    req_v[0] = 1'b0;
    repeat (4) tick();
    check("pre_abort_rdata", rdata_v[0], 8'h3C);
    req_v[0] = 1'b1; addr_v[0] = 16'h0033;
    tick();
    req_v[0] = 1'b0;
    tick();
    tick();
    clear_counts();
    reset_v[0] = 1'b1;
    tick();
    check("abort_busy", busy_v[0], 1'b0);
    check("abort_oe", oe_v[0], 1'b0);
    check("abort_rdata", rdata_v[0], 8'h00);
    reset_v[0] = 1'b0;
    repeat (3) tick();
    check("abort_no_done", done_cnt[0], 0);

    // reset and req together: reset wins.
    reset_v[1] = 1'b1; req_v[1] = 1'b1; addr_v[1] = 16'h1234;
    tick();
    check("rst_req_busy", busy_v[1], 1'b0);
    check("rst_req_cs", cs_v[1], 1'b0);
    idle_inputs(1);
    tick();
    check("rst_req_still_idle", cs_v[1], 1'b0);

`ifdef MEM_READY_EN
    // mem_ready low for three cycles once the wait count is exhausted.
    clear_counts();
    req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 16'h4477; ready_v[0] = 1'b0;
    tick();
    req_v[0] = 1'b0;
    repeat (5) tick();
    ready_v[0] = 1'b1;
    tick();
    repeat (2) tick();
    check("ready_oe_cycles", oe_cnt[0], 5);
    check("ready_rdata_5a", rdata_v[0], 8'h5A);
    check("ready_done_pulses", done_cnt[0], 1);
`endif

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 2; i++) begin
        reset_v[i] = ($urandom_range(63) == 0);
        req_v[i]   = ($urandom_range(2) != 0);
        we_v[i]    = 1'($urandom);
        addr_v[i]  = AW'($urandom);
        wdata_v[i] = DW'($urandom);
        ready_v[i] = ($urandom_range(3) != 0);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
Memory access sequencer that sits directly downstream of the address register.
- Consumes the 16-bit `address` the address register drives when OE_A is high, plus a write byte from the CPU data bus.
- Runs a fixed-timing chip-select / write-enable / output-enable sequence toward external RAM/ROM.
- Returns the read byte and a one-cycle completion pulse to the control unit.
- One access in flight at a time; no queuing.

Parameters:
- DATA_WIDTH, default `DATA_WIDTH (8): data byte width.
- ADDR_WIDTH, default 2*`DATA_WIDTH (16): address width.
- WAIT_STATES, default 1: extra ACCESS cycles beyond the minimum of one; legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high; all state returns to reset values at the next edge.
- req  input  1  access request; sampled only in IDLE.
- we  input  1  1 = write, 0 = read; sampled with req.
- addr_in  input  ADDR_WIDTH  address from the address register `address` output; sampled with req.
- wdata  input  DATA_WIDTH  write byte; sampled with req.
- rdata  output  DATA_WIDTH  last read byte; held until the next completed read.
- busy  output  1  high in every state other than IDLE.
- done  output  1  one-cycle pulse during HOLD.
- mem_addr  output  ADDR_WIDTH  registered address to memory.
- mem_wdata  output  DATA_WIDTH  registered write byte to memory.
- mem_rdata  input  DATA_WIDTH  read byte from memory.
- mem_cs  output  1  memory chip select.
- mem_we  output  1  memory write strobe.
- mem_oe  output  1  memory output enable.

Behaviour:
- Interface: one clock (clk); reset synchronous, active-high.
- State machine states, all outputs decoded from the state register (Moore):
  - IDLE: busy=0, mem_cs=0, mem_we=0, mem_oe=0, done=0.
  - SETUP: busy=1, mem_cs=1, mem_addr/mem_wdata valid, strobes 0.
  - ACCESS: busy=1, mem_cs=1, mem_we=we_q for a write, mem_oe=~we_q for a read.
  - HOLD: busy=1, mem_cs=1, strobes 0, done=1.
- Transitions:
  - IDLE→SETUP on req=1. At the same edge capture addr_in→mem_addr, wdata→mem_wdata, we→we_q.
  - SETUP→ACCESS unconditionally. Load wait counter with WAIT_STATES.
  - ACCESS: if count==0 → HOLD; otherwise decrement and stay. ACCESS therefore lasts WAIT_STATES+1 cycles.
  - On the ACCESS→HOLD edge of a read, mem_rdata→rdata. A write leaves rdata unchanged.
  - HOLD→IDLE unconditionally.
- Latency: req seen at edge E0 → done high in the cycle after edge E(2+WAIT_STATES) → busy low after E(3+WAIT_STATES).
  - Total 3+WAIT_STATES cycles per access.
  - Back-to-back throughput is one access per 4+WAIT_STATES cycles. The earliest next req is accepted in the IDLE cycle following HOLD.
- req while busy=1 is ignored and not remembered. The requester must hold req, or re-issue it after done.
- mem_addr and mem_wdata hold their values after HOLD until the next accepted req. This gives stable address/data for the bus hold time.
- Reset values: state IDLE, counter 0, rdata 0, mem_addr 0, mem_wdata 0, we_q 0, all strobes/busy/done 0.
- Reset mid-access aborts immediately: strobes drop at the next edge, no done pulse, rdata cleared.
- reset together with req: reset wins; the request is dropped.
- WAIT_STATES=0: ACCESS lasts exactly one cycle.
- The counter is $clog2(WAIT_STATES+1) bits wide, minimum 1 bit.

Optional Feature:
MEM_READY_EN
- Defined: adds input mem_ready (1 bit).
  - In ACCESS with count==0, stay in ACCESS while mem_ready=0; move to HOLD on the first cycle mem_ready=1.
  - rdata is captured on that exit edge.
  - mem_ready is ignored in every other state and while count!=0.
  - No timeout.
- Undefined: port absent; fixed timing as above.

Decomposition:
- Shared defines file:
  - state encodings (MBC_IDLE=2'd0, MBC_SETUP=2'd1, MBC_ACCESS=2'd2, MBC_HOLD=2'd3);
  - `DATA_WIDTH reused;
  - MBC_MAX_WAIT=15.
- One sub-module, wait_counter: loadable down-counter with a zero flag.
  - Parameter WIDTH.
  - Ports: clk, reset, load, load_val, dec, zero.

Test Plan:
- Read, WAIT_STATES=1, addr_in=16'h12A5, model returns 8'h3C → mem_oe high for exactly 2 cycles, mem_we never high, done pulses once 4 cycles after req, rdata=8'h3C.
- Write, WAIT_STATES=0, addr_in=16'hFFFF, wdata=8'hA5 → mem_we high for 1 cycle with mem_addr=16'hFFFF and mem_wdata=8'hA5; rdata unchanged; done at cycle 3.
- req held high continuously, mixing reads/writes → accesses every 5 cycles (WAIT_STATES=1); req during busy never starts an extra access.
- reset asserted in the second ACCESS cycle of a read → next cycle all strobes 0, busy=0, done never pulses, rdata=0.
- reset and req high in the same cycle from IDLE → stays IDLE, mem_cs stays 0.
- With MEM_READY_EN defined, mem_ready held low for 3 cycles after count exhausts, memory returning 8'h5A → mem_oe extends 3 extra cycles; rdata=8'h5A sampled on the mem_ready=1 edge.
